// File: rtl/snitch_icache_perf_counters.sv
// Instruction-cache performance counters: one registered event stage feeding one
// saturating counter per event bit, read (or read-and-cleared) over a req/rsp handshake.
package snitch_icache_pkg;
  typedef struct packed {
    logic l0_stall;
    logic l0_double_hit;
    logic l0_prefetch;
    logic l0_hit;
    logic l0_miss;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_handler_stall;
    logic l1_stall;
    logic l1_hit;
    logic l1_miss;
  } icache_l1_events_t;
endpackage

module snitch_icache_perf_counters
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 4,
  parameter int unsigned COUNTER_WIDTH  = 32,
  localparam int unsigned NUM_CNT = 5 * NR_FETCH_PORTS + 4,
  localparam int unsigned AW      = $clog2(NUM_CNT)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
  input  icache_l1_events_t                      l1_events_i,
  input  logic                                   enable_i,
  input  logic                                   clear_i,
  input  logic                                   req_valid_i,
  output logic                                   req_ready_o,
  input  logic [AW-1:0]                          req_addr_i,
  input  logic                                   req_clear_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [31:0]                            rsp_data_o
);

  logic [NUM_CNT-1:0]       ev_flat;
  logic [NUM_CNT-1:0]       ev_d, ev_q;
  logic [COUNTER_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [COUNTER_WIDTH-1:0] cnt_q [NUM_CNT];
  logic                     rsp_valid_d, rsp_valid_q;
  logic [31:0]              rsp_data_d, rsp_data_q;
  logic                     rd_accept;
  logic                     rd_in_range;
  logic [31:0]              rd_idx;

  // Packed concatenation puts port p, field k at bit p*5+k and L1 fields above all ports.
  assign ev_flat = {l1_events_i, l0_events_i};

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

  assign rd_accept   = req_valid_i && req_ready_o;
  assign rd_idx      = 32'(req_addr_i);
  assign rd_in_range = rd_idx < NUM_CNT;

  always_comb begin
    ev_d = '0;
    if (!clear_i && enable_i) begin
      ev_d = ev_flat;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ev_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
      end
      // Read-and-clear restarts from this cycle's pending event so it is not lost.
      if (rd_accept && req_clear_i && (rd_idx == i)) begin
        cnt_d[i] = COUNTER_WIDTH'(ev_q[i]);
      end
      if (clear_i) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    if (rd_accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      if (rd_in_range) begin
        rsp_data_d[COUNTER_WIDTH-1:0] = cnt_q[req_addr_i];
      end
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ev_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      ev_q        <= ev_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
# snitch_icache_perf_counters

Performance-counter bank downstream of the instruction cache. Consumes the per-cycle L0 event vectors from every fetch port and the L1 event vector, registers them once, and accumulates each event bit into its own saturating counter. Counters are read, optionally read-and-cleared, by the cluster peripheral block over a request/response handshake. Global enable and clear inputs are provided.

## Interface

- `NR_FETCH_PORTS`, default 4: number of L0 event vectors.
- `COUNTER_WIDTH`, default 32: width of each counter, range 1..32.
- Derived `NUM_CNT` = 5*NR_FETCH_PORTS + 4.
- Derived `AW` = $clog2(NUM_CNT).

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `l0_events_i`  in  NR_FETCH_PORTS x icache_l0_events_t  per-port L0 events, one bit per field, single-cycle pulses.
- `l1_events_i`  in  icache_l1_events_t  L1 events.
- `enable_i`  in  1  event sampling enable.
- `clear_i`  in  1  synchronous clear of all counters and the event register.
- `req_valid_i`  in  1  read request valid.
- `req_ready_o`  out  1  read request ready.
- `req_addr_i`  in  AW  counter index.
- `req_clear_i`  in  1  read-and-clear.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accepted.
- `rsp_data_o`  out  32  counter value, zero-extended.

## Operation

- Counter map: index p*5+k holds fetch port p, field k of l0 in order l0_miss=0, l0_hit=1, l0_prefetch=2, l0_double_hit=3, l0_stall=4.
- Index 5*NR_FETCH_PORTS+k holds L1 field k in order l1_miss=0, l1_hit=1, l1_stall=2, l1_handler_stall=3.
- Event register `ev_q` (NUM_CNT bits): each cycle loads the flattened events ANDed with enable_i.
- Each counter adds ev_q[i] each cycle.
- Counters saturate at 2^COUNTER_WIDTH-1 and never wrap.
- clear_i high: every counter and ev_q become 0 at the next edge. This overrides increments, read-and-clear, and new sampling.
- Read accept: req_valid_i && req_ready_o. req_ready_o = !rsp_valid_o || rsp_ready_i.
- On accept, the response register captures counter[req_addr_i], or 0 if req_addr_i >= NUM_CNT.
- Accepted read with req_clear_i=1 on a valid index: the counter next value is ev_q[idx], so an increment in the same cycle is not lost.
- Response register and rsp_valid_o hold stable until rsp_ready_i. A new accept can occur in the same cycle the old response is taken, which gives back-to-back throughput.
- A read with req_clear_i=1 to an out-of-range index returns 0 and affects nothing.
- Reset: all counters 0, ev_q 0, rsp_valid_o 0, rsp_data_o 0, req_ready_o 1 (combinational from rsp_valid_o).

## Timing

- Event pulse at cycle t with enable_i=1: latched into ev_q at the edge ending t. The counter increments at the edge ending t+1.
- The incremented value is visible to a read accepted in cycle t+2 or later.
- Read accepted in cycle t: rsp_valid_o=1 from t+1. Data equals the counter value during cycle t, before that cycle's increment.
- clear_i in cycle t: counters read 0 for accepts in t+1. Events presented in t-1 or t are discarded.
- enable_i low in cycle t drops cycle-t events only. Events already in ev_q still count.
- An async reset assertion mid-response drops rsp_valid_o immediately. No response is replayed.

## Test plan

- Reset, then read index 0 -> rsp_valid_o one cycle after accept, rsp_data_o=0; after reset, req_ready_o=1.
- Pulse port-1 l0_hit for 3 cycles with enable_i=1, wait 2 cycles, read index 6 -> 3; read indices 5 and 7 -> 0.
- Pulse l1_stall for 10 cycles with enable_i low on cycles 4-5, then read index 5*4+2=22 -> 8.
- COUNTER_WIDTH=4: pulse l0_miss on port 0 for 20 cycles -> read returns 15 with no wrap. Then read-and-clear with l0_miss still high -> response 15, next read 1 or more.
- Hold rsp_ready_i low for 5 cycles with req_valid_i high -> req_ready_o=0 and rsp_data_o stable throughout. Raise rsp_ready_i with back-to-back reads of indices 1,2,3 -> one response per cycle, in order.
- Pulse clear_i while all events are high -> every index reads 0 on the cycle after. Read index 24 (out of range) -> 0.
